// File: rtl/cpu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// size decoding and alignment checks.
package cpu_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_LOAD_WAIT  = 2'd1,
        LSU_STORE_WAIT = 2'd2,
        LSU_RESP       = 2'd3
    } lsu_state_e;

    // Reserved encodings fall back to a full word.
    function automatic logic [2:0] size_to_bytes(input mem_size_e size);
        case (size)
            MEM_B, MEM_BU: size_to_bytes = 3'd1;
            MEM_H, MEM_HU: size_to_bytes = 3'd2;
            default:       size_to_bytes = 3'd4;
        endcase
    endfunction

    // Reserved encodings are reported as faulting accesses.
    function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            MEM_B, MEM_BU: access_misaligned = 1'b0;
            MEM_H, MEM_HU: access_misaligned = addr_lo[0];
            MEM_W:         access_misaligned = |addr_lo;
            default:       access_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data formatter: selects the low byte/half/word of the raw
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_extend
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    // Size/sign selection of the fetched word.
    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            MEM_B:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            MEM_H:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            MEM_BU:  data_o = {24'h00_0000, raw_i[7:0]};
            MEM_HU:  data_o = {16'h0000, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and the memory data port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (fault misaligned/illegal accesses).
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int MEM_READ_LATENCY = 1,
    parameter int XLEN             = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_fetch_addr,
    input  logic [XLEN-1:0] mem_fetched_data,
    output logic [2:0]      mem_bytes_to_write,
    output logic [XLEN-1:0] mem_write_addr,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write_data_valid,
    input  logic            mem_write_done
);

    localparam int CNT_W = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_READ_LATENCY - 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            ready_q, ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic            resp_fault_q, resp_fault_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [2:0]      bytes_q, bytes_d;
    logic [XLEN-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wvalid_q, wvalid_d;
    logic [31:0]     ext_data_s;
    logic            access_fault_s;

    lsu_load_extend u_extend (
        .funct3_i (funct3_q),
        .raw_i    (mem_fetched_data[31:0]),
        .data_o   (ext_data_s)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign access_fault_s = access_misaligned(req_funct3, req_addr[1:0]);
`else
    assign access_fault_s = 1'b0;
`endif

    // Next-state and registered-output logic for the request FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_fault_d = resp_fault_q;
        fetch_addr_d = fetch_addr_q;
        bytes_d      = bytes_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wvalid_d     = wvalid_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    rd_d     = req_rd;
                    if (access_fault_s) begin
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_data_d  = '0;
                        resp_rd_d    = 5'd0;
                    end else if (req_is_store) begin
                        state_d  = LSU_STORE_WAIT;
                        waddr_d  = req_addr;
                        wdata_d  = req_wdata;
                        bytes_d  = size_to_bytes(mem_size_e'(req_funct3));
                        wvalid_d = 1'b1;
                    end else begin
                        state_d      = LSU_LOAD_WAIT;
                        fetch_addr_d = req_addr;
                        cnt_d        = '0;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_LOAD_WAIT: begin
                // Capture on the MEM_READ_LATENCY-th edge after the address changed.
                if (cnt_q == LAT_LAST) begin
                    state_d      = LSU_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_data_d  = XLEN'(ext_data_s);
                    resp_rd_d    = rd_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_STORE_WAIT: begin
                if (mem_write_done) begin
                    state_d      = LSU_RESP;
                    wvalid_d     = 1'b0;
                    bytes_d      = 3'd0;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_data_d  = '0;
                    resp_rd_d    = 5'd0;
                end else begin
                    state_d = LSU_STORE_WAIT;
                end
            end
            LSU_RESP: begin
                state_d      = LSU_IDLE;
                resp_valid_d = 1'b0;
            end
            default: begin
                state_d      = LSU_IDLE;
                resp_valid_d = 1'b0;
                wvalid_d     = 1'b0;
                bytes_d      = 3'd0;
            end
        endcase
        ready_d = (state_d == LSU_IDLE);
    end

    // State and output registers; reset abandons any in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            funct3_q     <= 3'd0;
            rd_q         <= 5'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= 5'd0;
            resp_fault_q <= 1'b0;
            fetch_addr_q <= '0;
            bytes_q      <= 3'd0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_fault_q <= resp_fault_d;
            fetch_addr_q <= fetch_addr_d;
            bytes_q      <= bytes_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wvalid_q     <= wvalid_d;
        end
    end

    assign req_ready            = ready_q;
    assign resp_valid           = resp_valid_q;
    assign resp_data            = resp_data_q;
    assign resp_rd              = resp_rd_q;
    assign resp_fault           = resp_fault_q;
    assign mem_fetch_addr       = fetch_addr_q;
    assign mem_bytes_to_write   = bytes_q;
    assign mem_write_addr       = waddr_q;
    assign mem_write_data       = wdata_q;
    assign mem_write_data_valid = wvalid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-addressed memory model
// (combinational read, one-cycle registered write_done, optional write stall).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [31:0] mem_fetch_addr;
    logic [31:0] mem_fetched_data;
    logic [2:0]  mem_bytes_to_write;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_data_valid;
    logic        mem_write_done;
    logic        stall = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int wdv_cycles = 0;

    load_store_unit #(.MEM_READ_LATENCY(1), .XLEN(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_is_store         (req_is_store),
        .req_funct3           (req_funct3),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .req_rd               (req_rd),
        .resp_valid           (resp_valid),
        .resp_data            (resp_data),
        .resp_rd              (resp_rd),
        .resp_fault           (resp_fault),
        .mem_fetch_addr       (mem_fetch_addr),
        .mem_fetched_data     (mem_fetched_data),
        .mem_bytes_to_write   (mem_bytes_to_write),
        .mem_write_addr       (mem_write_addr),
        .mem_write_data       (mem_write_data),
        .mem_write_data_valid (mem_write_data_valid),
        .mem_write_done       (mem_write_done)
    );

    always #5 clk = ~clk;

    // Memory model: 512 bytes, reset loads the test image.
    logic [7:0] mem_b [0:511];
    logic [8:0] fa;
    always_comb begin
        fa = mem_fetch_addr[8:0];
        mem_fetched_data = {mem_b[fa + 9'd3], mem_b[fa + 9'd2], mem_b[fa + 9'd1], mem_b[fa]};
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 512; i++) mem_b[i] <= 8'h00;
            mem_b[0] <= 8'hef; mem_b[1] <= 8'hbe; mem_b[2]  <= 8'had; mem_b[3]  <= 8'hde;
            mem_b[4] <= 8'hdd; mem_b[5] <= 8'hcc; mem_b[6]  <= 8'hbb; mem_b[7]  <= 8'haa;
            mem_b[8] <= 8'hff; mem_b[9] <= 8'hff; mem_b[10] <= 8'hff; mem_b[11] <= 8'hff;
            mem_write_done <= 1'b0;
        end else if (mem_write_data_valid && !mem_write_done && !stall) begin
            for (int i = 0; i < 4; i++)
                if (i < int'(mem_bytes_to_write))
                    mem_b[mem_write_addr[8:0] + 9'(i)] <= mem_write_data[8*i +: 8];
            mem_write_done <= 1'b1;
        end else begin
            mem_write_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (mem_write_data_valid) wdv_cycles <= wdv_cycles + 1;
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic [2:0]  exp_bytes;
        logic [3:0]  exp_lat;
        logic        exp_fault;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic [31:0] od, output logic [4:0] ord, output logic of,
                          output logic [2:0] ob, output int lat);
        req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        ob  = mem_bytes_to_write;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            step();
            lat++;
        end
        od = resp_data; ord = resp_rd; of = resp_fault;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] od;
        logic [4:0]  ord;
        logic        of;
        logic [2:0]  ob;
        int          lat;
        do_req(v.st, v.f3, v.addr, v.wdata, v.rd, od, ord, of, ob, lat);
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " data"}, od, v.exp_data);
        check({tag, " rd"}, 32'(ord), 32'(v.exp_rd));
        check({tag, " fault"}, 32'(of), 32'(v.exp_fault));
        check({tag, " bytes_to_write"}, 32'(ob), 32'(v.exp_bytes));
        step();
        check({tag, " resp pulse end"}, 32'(resp_valid), 32'd0);
        check({tag, " ready after resp"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] od;
        logic [4:0]  ord;
        logic        of;
        logic [2:0]  ob;
        int          lat;
        int          w0;
        int          a0;
        int          bound;
        logic [31:0] exp6 [3];

        vt[0]  = '{1'b1, 3'b010, 32'h100, 32'hdead_beef, 5'd7,  32'h0,         5'd0,  3'd4, 4'd3, 1'b0};
        vt[1]  = '{1'b0, 3'b010, 32'h100, 32'h0,         5'd5,  32'hdead_beef, 5'd5,  3'd0, 4'd2, 1'b0};
        vt[2]  = '{1'b0, 3'b000, 32'h100, 32'h0,         5'd1,  32'hffff_ffef, 5'd1,  3'd0, 4'd2, 1'b0};
        vt[3]  = '{1'b0, 3'b100, 32'h100, 32'h0,         5'd2,  32'h0000_00ef, 5'd2,  3'd0, 4'd2, 1'b0};
        vt[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,         5'd3,  32'hffff_dead, 5'd3,  3'd0, 4'd2, 1'b0};
        vt[5]  = '{1'b0, 3'b101, 32'h102, 32'h0,         5'd4,  32'h0000_dead, 5'd4,  3'd0, 4'd2, 1'b0};
        vt[6]  = '{1'b1, 3'b010, 32'h104, 32'hdead_beef, 5'd6,  32'h0,         5'd0,  3'd4, 4'd3, 1'b0};
        vt[7]  = '{1'b1, 3'b001, 32'h104, 32'hb0ba_cafe, 5'd3,  32'h0,         5'd0,  3'd2, 4'd3, 1'b0};
        vt[8]  = '{1'b0, 3'b010, 32'h104, 32'h0,         5'd8,  32'hdead_cafe, 5'd8,  3'd0, 4'd2, 1'b0};
        vt[9]  = '{1'b1, 3'b010, 32'h100, 32'h0,         5'd0,  32'h0,         5'd0,  3'd4, 4'd3, 1'b0};
        vt[10] = '{1'b1, 3'b000, 32'h101, 32'h0000_0011, 5'd0,  32'h0,         5'd0,  3'd1, 4'd3, 1'b0};
        vt[11] = '{1'b0, 3'b010, 32'h100, 32'h0,         5'd10, 32'h0000_1100, 5'd10, 3'd0, 4'd2, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vt[12] = '{1'b0, 3'b011, 32'h104, 32'h0,         5'd9,  32'h0,         5'd0,  3'd0, 4'd1, 1'b1};
`else
        vt[12] = '{1'b0, 3'b011, 32'h104, 32'h0,         5'd9,  32'hdead_cafe, 5'd9,  3'd0, 4'd2, 1'b0};
`endif

        // Reset state
        step();
        step();
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset resp_rd", 32'(resp_rd), 32'd0);
        check("reset resp_fault", 32'(resp_fault), 32'd0);
        check("reset bytes_to_write", 32'(mem_bytes_to_write), 32'd0);
        check("reset write_data_valid", 32'(mem_write_data_valid), 32'd0);
        check("reset fetch_addr", mem_fetch_addr, 32'd0);
        check("reset write_addr", mem_write_addr, 32'd0);
        check("reset write_data", mem_write_data, 32'd0);
        rst = 1'b1;
        step();

        // Store held while memory stalls write_done
        stall = 1'b1;
        req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
        req_wdata = 32'hdead_beef; req_rd = 5'd7; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        check("held bytes_to_write", 32'(mem_bytes_to_write), 32'd4);
        check("held write_data_valid", 32'(mem_write_data_valid), 32'd1);
        check("held write_addr", mem_write_addr, 32'h100);
        check("held write_data", mem_write_data, 32'hdead_beef);
        check("held req_ready", 32'(req_ready), 32'd0);
        check("held resp_valid", 32'(resp_valid), 32'd0);
        stall = 1'b0;
        bound = 0;
        while (!resp_valid && bound < 40) begin
            step();
            bound++;
        end
        check("held store resp timeout", 32'(resp_valid), 32'd1);
        check("held store resp_rd", 32'(resp_rd), 32'd0);
        check("held store resp_data", resp_data, 32'd0);
        check("held store wdv cleared", 32'(mem_write_data_valid), 32'd0);
        check("held store bytes cleared", 32'(mem_bytes_to_write), 32'd0);
        step();
        check("held store pulse end", 32'(resp_valid), 32'd0);

        // Table vectors
        for (int i = 0; i < 13; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        check("fetch_addr after loads", mem_fetch_addr, 32'h104);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word store faults without touching memory
        w0 = wdv_cycles;
        do_req(1'b1, 3'b010, 32'h101, 32'h1234_5678, 5'd4, od, ord, of, ob, lat);
        check("trap latency", 32'(lat), 32'd1);
        check("trap fault", 32'(of), 32'd1);
        check("trap data", od, 32'd0);
        check("trap rd", 32'(ord), 32'd0);
        step();
        check("trap wdv never", 32'(wdv_cycles - w0), 32'd0);
        check("trap memory unchanged", {mem_b[9'h104], mem_b[9'h103], mem_b[9'h102], mem_b[9'h101]},
              32'hfe00_0011);
`endif

        // Reset asserted in the middle of a stalled store
        stall = 1'b1;
        req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10c;
        req_wdata = 32'h1234_5678; req_rd = 5'd0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("mid-store wdv before reset", 32'(mem_write_data_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("mid-store reset wdv", 32'(mem_write_data_valid), 32'd0);
        check("mid-store reset bytes", 32'(mem_bytes_to_write), 32'd0);
        check("mid-store reset ready", 32'(req_ready), 32'd1);
        step();
        rst = 1'b1;
        stall = 1'b0;
        step();
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 5'd12, od, ord, of, ob, lat);
        check("post-reset load data", od, 32'haabb_ccdd);
        check("post-reset load rd", 32'(ord), 32'd12);
        check("post-reset load latency", 32'(lat), 32'd2);
        step();

        // Back-to-back loads with req_valid held high
        exp6[0] = 32'hdead_beef; exp6[1] = 32'haabb_ccdd; exp6[2] = 32'hffff_ffff;
        a0 = acc_cnt;
        req_is_store = 1'b0; req_funct3 = 3'b010; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'(4 * k);
            req_rd   = 5'(20 + k);
            bound = 0;
            while (!req_ready && bound < 40) begin
                step();
                bound++;
            end
            check($sformatf("b2b%0d ready wait", k), 32'(req_ready), 32'd1);
            step();
            check($sformatf("b2b%0d busy after accept", k), 32'(req_ready), 32'd0);
            bound = 0;
            while (!resp_valid && bound < 40) begin
                step();
                bound++;
            end
            check($sformatf("b2b%0d resp timeout", k), 32'(resp_valid), 32'd1);
            check($sformatf("b2b%0d data", k), resp_data, exp6[k]);
            check($sformatf("b2b%0d rd", k), 32'(resp_rd), 32'(20 + k));
        end
        req_valid = 1'b0;
        step();
        step();
        check("b2b accept count", 32'(acc_cnt - a0), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
